snake_body_engine: RTL and testbench

- Owns the snake: head position, segment history, length, growth and self-collision.
- Produces the 8x8 occupancy bitmap row_1..row_8 that the food logic scans for free cells.
- Produces the head coordinates that the food logic compares against the food position.
- Consumes food_collide from the food logic to grow; one move per step pulse from the game-tick divider.

---
 rtl/snake_body_engine.sv | 195 +++++++++++++++++++
 tb/tb_snake_body_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// Snake body engine: owns head, segment history, growth, self-collision and the 8x8 occupancy bitmap.
// Optional build macro WALL_DEATH_EN: a move that would wrap across the board edge kills the snake instead.
module snake_body_engine #(
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 3,
   parameter int START_Y  = 3
) (
   input  logic       clk_snake,
   input  logic       reset,
   input  logic       step,
   input  logic [1:0] dir,
   input  logic       food_collide,
   output logic [2:0] head_x,
   output logic [2:0] head_y,
   output logic [7:0] row_1,
   output logic [7:0] row_2,
   output logic [7:0] row_3,
   output logic [7:0] row_4,
   output logic [7:0] row_5,
   output logic [7:0] row_6,
   output logic [7:0] row_7,
   output logic [7:0] row_8,
   output logic [5:0] length,
   output logic       busy,
   output logic       game_over
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {IDLE, MOVE, RENDER, COMMIT, DEAD} state_t;

   state_t       state_r;
   state_t       next_state_s;
   logic [2:0]   seg_x_r [MAX_LEN];
   logic [2:0]   seg_y_r [MAX_LEN];
   logic [5:0]   length_r;
   logic [1:0]   cur_dir_r;
   logic         grow_pending_r;
   logic         food_prev_r;
   logic [IW-1:0] index_r;
   logic [63:0]  shadow_r;
   logic         hit_r;
   logic [7:0]   rows_r [8];
   logic         busy_r;
   logic         game_over_r;
   logic [2:0]   next_x_s;
   logic [2:0]   next_y_s;
   logic         wall_hit_s;

   function automatic logic [7:0] init_row();
      logic [7:0] r;
      r = 8'd0;
      for (int i = 0; i < INIT_LEN; i++) begin
         r[3'(START_X - i)] = 1'b1;
      end
      return r;
   endfunction

   // Candidate head position one cell along the current direction (3-bit wrap).
   always_comb begin
      next_x_s = seg_x_r[0];
      next_y_s = seg_y_r[0];
      case (cur_dir_r)
         2'b00:   next_x_s = seg_x_r[0] + 3'd1;
         2'b01:   next_y_s = seg_y_r[0] + 3'd1;
         2'b10:   next_x_s = seg_x_r[0] - 3'd1;
         2'b11:   next_y_s = seg_y_r[0] - 3'd1;
         default: next_x_s = seg_x_r[0];
      endcase
   end

`ifdef WALL_DEATH_EN
   assign wall_hit_s = ((cur_dir_r == 2'b00) && (seg_x_r[0] == 3'd7)) ||
                       ((cur_dir_r == 2'b01) && (seg_y_r[0] == 3'd7)) ||
                       ((cur_dir_r == 2'b10) && (seg_x_r[0] == 3'd0)) ||
                       ((cur_dir_r == 2'b11) && (seg_y_r[0] == 3'd0));
`else
   assign wall_hit_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_snake) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (step) next_state_s = MOVE;
            else      next_state_s = IDLE;
         end
         MOVE: begin
            if (wall_hit_s) next_state_s = DEAD;
            else            next_state_s = RENDER;
         end
         RENDER: begin
            if (6'(index_r) == (length_r - 6'd1)) next_state_s = COMMIT;
            else                                  next_state_s = RENDER;
         end
         COMMIT: begin
            if (hit_r) next_state_s = DEAD;
            else       next_state_s = IDLE;
         end
         DEAD:    next_state_s = DEAD;
         default: next_state_s = IDLE;
      endcase
   end

   // Segment history, growth latch, render walk and committed frame.
   always_ff @(posedge clk_snake) begin
      if (!reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_r[i] <= (i < INIT_LEN) ? 3'(START_X - i) : 3'd0;
            seg_y_r[i] <= (i < INIT_LEN) ? 3'(START_Y) : 3'd0;
         end
         for (int k = 0; k < 8; k++) begin
            rows_r[k] <= (k == START_Y) ? init_row() : 8'd0;
         end
         length_r       <= 6'(INIT_LEN);
         cur_dir_r      <= 2'b00;
         grow_pending_r <= 1'b0;
         food_prev_r    <= 1'b0;
         index_r        <= '0;
         shadow_r       <= 64'd0;
         hit_r          <= 1'b0;
         busy_r         <= 1'b0;
         game_over_r    <= 1'b0;
      end else begin
         food_prev_r <= food_collide;
         if ((state_r != DEAD) && food_collide && !food_prev_r) begin
            grow_pending_r <= 1'b1;
         end else if (state_r == MOVE) begin
            grow_pending_r <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               if (step && (dir != (cur_dir_r ^ 2'b10))) cur_dir_r <= dir;
            end
            MOVE: begin
               shadow_r <= 64'd0;
               hit_r    <= 1'b0;
               index_r  <= '0;
               if (!wall_hit_s) begin
                  for (int i = 1; i < MAX_LEN; i++) begin
                     seg_x_r[i] <= seg_x_r[i-1];
                     seg_y_r[i] <= seg_y_r[i-1];
                  end
                  seg_x_r[0] <= next_x_s;
                  seg_y_r[0] <= next_y_s;
                  // Shifting always keeps the old tail in the buffer; growing just extends the live length over it.
                  if (grow_pending_r && (length_r < 6'(MAX_LEN))) length_r <= length_r + 6'd1;
               end
            end
            RENDER: begin
               shadow_r[{seg_y_r[index_r], seg_x_r[index_r]}] <= 1'b1;
               if ((index_r != '0) &&
                   ({seg_y_r[index_r], seg_x_r[index_r]} == {seg_y_r[0], seg_x_r[0]})) begin
                  hit_r <= 1'b1;
               end
               index_r <= index_r + 1'b1;
            end
            COMMIT: begin
               for (int k = 0; k < 8; k++) begin
                  rows_r[k] <= shadow_r[k*8 +: 8];
               end
            end
            default: ;
         endcase
         busy_r      <= (next_state_s == MOVE) || (next_state_s == RENDER) || (next_state_s == COMMIT);
         game_over_r <= (next_state_s == DEAD);
      end
   end

   assign head_x    = seg_x_r[0];
   assign head_y    = seg_y_r[0];
   assign length    = length_r;
   assign busy      = busy_r;
   assign game_over = game_over_r;
   assign row_1     = rows_r[0];
   assign row_2     = rows_r[1];
   assign row_3     = rows_r[2];
   assign row_4     = rows_r[3];
   assign row_5     = rows_r[4];
   assign row_6     = rows_r[5];
   assign row_7     = rows_r[6];
   assign row_8     = rows_r[7];

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus random moves checked against a queue-based snake model.
// Honours WALL_DEATH_EN when the build defines it.
module tb_snake_body_engine;
   localparam int MAX_LEN = 16, INIT_LEN = 3, START_X = 3, START_Y = 3;

   logic clk = 1'b0, reset = 1'b0, step = 1'b0, food = 1'b0;
   logic [1:0] dir = 2'b00;
   logic [2:0] head_x, head_y;
   logic [7:0] row_1, row_2, row_3, row_4, row_5, row_6, row_7, row_8;
   logic [5:0] length;
   logic busy, game_over;

   snake_body_engine #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .START_X(START_X), .START_Y(START_Y)) dut (
      .clk_snake(clk), .reset(reset), .step(step), .dir(dir), .food_collide(food),
      .head_x(head_x), .head_y(head_y),
      .row_1(row_1), .row_2(row_2), .row_3(row_3), .row_4(row_4),
      .row_5(row_5), .row_6(row_6), .row_7(row_7), .row_8(row_8),
      .length(length), .busy(busy), .game_over(game_over));

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;
   // Model: body as coordinate queues, head at index 0.
   int bx[$], by[$];
   logic [1:0] m_dir;
   bit m_grow, m_dead;

   function automatic logic [63:0] model_frame();
      logic [63:0] f;
      f = 64'd0;
      for (int i = 0; i < bx.size(); i++) f[by[i]*8 + bx[i]] = 1'b1;
      return f;
   endfunction

   function automatic logic [63:0] dut_frame();
      return {row_8, row_7, row_6, row_5, row_4, row_3, row_2, row_1};
   endfunction

   task automatic model_reset();
      bx.delete(); by.delete();
      for (int i = 0; i < INIT_LEN; i++) begin
         bx.push_back(START_X - i);
         by.push_back(START_Y);
      end
      m_dir = 2'b00; m_grow = 1'b0; m_dead = 1'b0;
   endtask

   task automatic model_move(input logic [1:0] d, output int exp_busy);
      int nx, ny;
      if (m_dead) begin exp_busy = 0; return; end
      if (d != (m_dir ^ 2'b10)) m_dir = d;
`ifdef WALL_DEATH_EN
      if ((m_dir == 2'd0 && bx[0] == 7) || (m_dir == 2'd1 && by[0] == 7) ||
          (m_dir == 2'd2 && bx[0] == 0) || (m_dir == 2'd3 && by[0] == 0)) begin
         m_dead = 1'b1; m_grow = 1'b0; exp_busy = 1; return;
      end
`endif
      nx = bx[0]; ny = by[0];
      case (m_dir)
         2'd0:    nx = (nx + 1) % 8;
         2'd1:    ny = (ny + 1) % 8;
         2'd2:    nx = (nx + 7) % 8;
         default: ny = (ny + 7) % 8;
      endcase
      bx.push_front(nx); by.push_front(ny);
      if (!(m_grow && (bx.size() - 1) < MAX_LEN)) begin
         void'(bx.pop_back()); void'(by.pop_back());
      end
      m_grow = 1'b0;
      for (int i = 1; i < bx.size(); i++) if (bx[i] == nx && by[i] == ny) m_dead = 1'b1;
      exp_busy = bx.size() + 2;
   endtask

   task automatic pulse_food();
      @(posedge clk); #1 food = 1'b1;
      @(posedge clk); #1 food = 1'b0;
      if (!m_dead) m_grow = 1'b1;
   endtask

   task automatic run_move(input logic [1:0] d, input bit poke);
      int exp_busy, cnt;
      model_move(d, exp_busy);
      @(posedge clk); #1 step = 1'b1; dir = d;
      @(posedge clk); #1 step = 1'b0;
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         if (k == 1) begin
            n_checks++;
            if (head_x !== 3'(bx[0]) || head_y !== 3'(by[0]))
               $display("FAIL head_after_move: got (%0d,%0d) expected (%0d,%0d)", head_x, head_y, bx[0], by[0]);
            else n_pass++;
         end
         if (busy !== 1'b1) break;
         step = (poke && k == 2);
         if (poke && k == 2) dir = 2'($urandom_range(3));
         cnt++;
         @(posedge clk); #1;
      end
      step = 1'b0;
      n_checks++;
      if (cnt != exp_busy) $display("FAIL busy_cycles: got %0d expected %0d", cnt, exp_busy);
      else n_pass++;
      n_checks++;
      if (dut_frame() !== model_frame()) $display("FAIL frame: got %h expected %h", dut_frame(), model_frame());
      else n_pass++;
      n_checks++;
      if (length !== 6'(bx.size()) || head_x !== 3'(bx[0]) || head_y !== 3'(by[0]))
         $display("FAIL len_head: got %0d (%0d,%0d) expected %0d (%0d,%0d)", length, head_x, head_y, bx.size(), bx[0], by[0]);
      else n_pass++;
      n_checks++;
      if (game_over !== m_dead) $display("FAIL game_over: got %b expected %b", game_over, m_dead);
      else n_pass++;
   endtask

   task automatic test_reset();
      @(posedge clk); #1 reset = 1'b0; step = 1'b0; food = 1'b0;
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      model_reset();
      n_checks++;
      if (row_4 !== 8'b0000_1110 || dut_frame() !== model_frame())
         $display("FAIL reset_rows: got %h expected %h", dut_frame(), model_frame());
      else n_pass++;
      n_checks++;
      if (head_x !== 3'd3 || head_y !== 3'd3 || length !== 6'd3 || busy !== 1'b0 || game_over !== 1'b0)
         $display("FAIL reset_state: got head (%0d,%0d) len %0d busy %b go %b expected (3,3) 3 0 0",
                  head_x, head_y, length, busy, game_over);
      else n_pass++;
   endtask

   task automatic test_reset_mid_render();
      @(posedge clk); #1 step = 1'b1; dir = 2'b01;
      @(posedge clk); #1 step = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      model_reset();
      n_checks++;
      if (dut_frame() !== model_frame() || head_x !== 3'd3 || head_y !== 3'd3 || busy !== 1'b0 || length !== 6'd3)
         $display("FAIL reset_mid_render: got frame %h head (%0d,%0d) busy %b len %0d expected frame %h (3,3) 0 3",
                  dut_frame(), head_x, head_y, busy, length, model_frame());
      else n_pass++;
   endtask

   task automatic test_move_right();
      run_move(2'b00, 1'b0);
      n_checks++;
      if (row_4 !== 8'b0001_1100) $display("FAIL move_right_row4: got %b expected 00011100", row_4);
      else n_pass++;
   endtask

   task automatic test_opposite_ignored();
      run_move(2'b10, 1'b0);
      n_checks++;
      if (head_x !== 3'd5 || head_y !== 3'd3) $display("FAIL opposite_dir: got (%0d,%0d) expected (5,3)", head_x, head_y);
      else n_pass++;
   endtask

   task automatic test_grow_and_busy_step();
      test_reset();
      run_move(2'b00, 1'b0);
      pulse_food();
      run_move(2'b00, 1'b1);
      n_checks++;
      if (length !== 6'd4 || row_4 !== 8'b0011_1100)
         $display("FAIL grow: got len %0d row_4 %b expected 4 00111100", length, row_4);
      else n_pass++;
   endtask

   task automatic test_wrap();
      test_reset();
      repeat (4) run_move(2'b00, 1'b0);
      run_move(2'b00, 1'b0);
      n_checks++;
`ifdef WALL_DEATH_EN
      if (game_over !== 1'b1 || head_x !== 3'd7) $display("FAIL wall_death: got go %b x %0d expected 1 7", game_over, head_x);
      else n_pass++;
`else
      if (head_x !== 3'd0 || row_4[0] !== 1'b1) $display("FAIL wrap: got x %0d row_4 %b expected x 0 bit0 set", head_x, row_4);
      else n_pass++;
`endif
   endtask

   task automatic test_self_collision();
      test_reset();
      pulse_food(); run_move(2'b00, 1'b0);
      pulse_food(); run_move(2'b00, 1'b0);
      run_move(2'b01, 1'b0);
      run_move(2'b10, 1'b0);
      run_move(2'b11, 1'b0);
      n_checks++;
      if (game_over !== 1'b1 || length !== 6'd5) $display("FAIL collision: got go %b len %0d expected 1 5", game_over, length);
      else n_pass++;
      run_move(2'b00, 1'b0);
      test_reset();
   endtask

   task automatic test_random();
      test_reset();
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(3) == 0) pulse_food();
         run_move(2'($urandom_range(3)), 1'($urandom_range(1)));
         if (m_dead) begin
            run_move(2'($urandom_range(3)), 1'b0);
            test_reset();
         end
      end
   endtask

   initial begin
      test_reset();
      test_move_right();
      test_opposite_ignored();
      test_reset();
      test_reset_mid_render();
      test_grow_and_busy_step();
      test_wrap();
      test_self_collision();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
